keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_if.sv | 17 +
 rtl/keypad_emulator.sv | 76 +++++++
 tb/tb_keypad_emulator.sv | 135 +++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// keypad_if: command handshake (cmd_*), scanner matrix (Col in, Row out) and status (busy, done, hit_count)
interface keypad_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_key;
  logic [7:0] cmd_hold;
  logic [2:0] cmd_bounce;
  logic [3:0] Col;
  logic [3:0] Row;
  logic       busy;
  logic       done;
  logic [7:0] hit_count;
  modport master (output cmd_valid, cmd_key, cmd_hold, cmd_bounce, Col,
                  input cmd_ready, Row, busy, done, hit_count);
  modport slave (input cmd_valid, cmd_key, cmd_hold, cmd_bounce, Col,
                 output cmd_ready, Row, busy, done, hit_count);
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: bouncing matrix-key press emulator; clk/reset plain ports, kp.slave carries command handshake, Col/Row matrix and status
module keypad_emulator #(
  parameter int BOUNCE_PERIOD = 2,
  parameter int RELEASE_GAP = 4
) (
  input logic clk,
  input logic reset,
  keypad_if.slave kp
);
  localparam logic [2:0] IDLE = 3'd0, BOUNCE_IN = 3'd1, HOLD = 3'd2, BOUNCE_OUT = 3'd3, GAP = 3'd4;
  localparam int MAXC0 = (2 * 7 * BOUNCE_PERIOD > 255) ? 2 * 7 * BOUNCE_PERIOD : 255;
  localparam int MAXC = (RELEASE_GAP > MAXC0) ? RELEASE_GAP : MAXC0;
  localparam int CW = $clog2(MAXC + 1);
  logic [2:0] r_state;
  logic [3:0] r_key;
  logic [7:0] r_hold;
  logic [2:0] r_n;
  logic [CW-1:0] r_cnt;
  logic [3:0] r_ph;
  logic r_done;
  logic [7:0] r_hit;
  logic w_accept, w_contact, w_ph_last, w_half_end;
  logic [3:0] w_row;
  assign w_accept = kp.cmd_valid && kp.cmd_ready;
  assign w_half_end = r_cnt == CW'(BOUNCE_PERIOD - 1);
  assign w_ph_last = r_ph == ({1'b0, r_n} << 1) - 4'd1;
  // bounce-in starts closed on even half-phases; bounce-out starts open, so odd half-phases close
  assign w_contact = (r_state == HOLD) || (r_state == BOUNCE_IN && !r_ph[0]) || (r_state == BOUNCE_OUT && r_ph[0]);
  assign w_row = (w_contact && kp.Col[r_key[1:0]]) ? (4'b0001 << r_key[3:2]) : 4'd0;
  assign kp.Row = w_row;
  assign kp.cmd_ready = r_state == IDLE && !reset;
  assign kp.busy = r_state != IDLE;
  assign kp.done = r_done;
  assign kp.hit_count = r_hit;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_key <= '0;
      r_hold <= '0;
      r_n <= '0;
      r_cnt <= '0;
      r_ph <= '0;
      r_done <= 1'b0;
      r_hit <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) r_hit <= '0;
      else if (kp.busy && |w_row && r_hit != 8'hff) r_hit <= r_hit + 8'd1;
      case (r_state)
        IDLE: if (kp.cmd_valid) begin
          r_key <= kp.cmd_key;
          r_hold <= (kp.cmd_hold == 8'd0) ? 8'd1 : kp.cmd_hold;
          r_n <= kp.cmd_bounce;
          r_cnt <= '0;
          r_ph <= '0;
          r_state <= (kp.cmd_bounce != 3'd0) ? BOUNCE_IN : HOLD;
        end
        BOUNCE_IN, BOUNCE_OUT: if (w_half_end) begin
          r_cnt <= '0;
          r_ph <= w_ph_last ? 4'd0 : r_ph + 4'd1;
          if (w_ph_last) r_state <= (r_state == BOUNCE_IN) ? HOLD : GAP;
        end else r_cnt <= r_cnt + CW'(1);
        HOLD: if (r_cnt == CW'(r_hold) - CW'(1)) begin
          r_cnt <= '0;
          r_state <= (r_n != 3'd0) ? BOUNCE_OUT : GAP;
        end else r_cnt <= r_cnt + CW'(1);
        GAP: if (r_cnt == CW'(RELEASE_GAP - 1)) begin
          r_cnt <= '0;
          r_state <= IDLE;
          r_done <= 1'b1;
        end else r_cnt <= r_cnt + CW'(1);
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed self-checking bench for keypad_emulator
module tb_keypad_emulator;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  keypad_if kp();
  keypad_emulator #(.BOUNCE_PERIOD(2), .RELEASE_GAP(4)) dut (.clk(clk), .reset(reset), .kp(kp));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic press(input logic [3:0] key, input logic [7:0] hold, input logic [2:0] bounce);
    @(negedge clk);
    kp.cmd_key = key;
    kp.cmd_hold = hold;
    kp.cmd_bounce = bounce;
    kp.cmd_valid = 1'b1;
    chk("ready", kp.cmd_ready, 1);
    @(posedge clk);
    #1 kp.cmd_valid = 1'b0;
  endtask
  task automatic trace(input string tag, input logic [31:0] pat, input int len, input logic [3:0] rb);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      chk(tag, kp.Row, pat[len-1-i] ? rb : 4'd0);
    end
  endtask
  task automatic end_chk(input string tag, input logic [7:0] hit);
    @(negedge clk);
    chk({tag, "_done"}, kp.done, 1);
    chk({tag, "_busy"}, kp.busy, 0);
    chk({tag, "_hit"}, kp.hit_count, hit);
  endtask
  task automatic wait_done(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (kp.done) break;
    end
    chk(tag, kp.done, 1);
  endtask
  initial begin
    logic [3:0] c;
    kp.cmd_valid = 1'b0;
    kp.cmd_key = 4'd0;
    kp.cmd_hold = 8'd0;
    kp.cmd_bounce = 3'd0;
    kp.Col = 4'hf;
    kp.cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_row", kp.Row, 0);
    chk("rst_busy", kp.busy, 0);
    chk("rst_ready", kp.cmd_ready, 0);
    chk("rst_done", kp.done, 0);
    chk("rst_hit", kp.hit_count, 0);
    kp.cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", kp.cmd_ready, 1);
    chk("idle_busy", kp.busy, 0);
    press(4'd6, 8'd5, 3'd0);
    trace("clean_row", 32'b111110000, 9, 4'b0010);
    end_chk("clean", 8'd5);
    @(negedge clk);
    chk("done_pulse_one", kp.done, 0);
    chk("hit_hold", kp.hit_count, 5);
    kp.Col = 4'b0001;
    press(4'd0, 8'd3, 3'd2);
    trace("bounce_row", 32'b11001100111001100110000, 23, 4'b0001);
    end_chk("bounce", 8'd11);
    kp.Col = 4'hf;
    press(4'd15, 8'd0, 3'd0);
    trace("hold0_row", 32'b10000, 5, 4'b1000);
    end_chk("hold0", 8'd1);
    press(4'd9, 8'd8, 3'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      c = 4'b0001 << i;
      kp.Col = c;
      #1 chk("colsel", kp.Row, (i == 1) ? 4'b0100 : 4'b0000);
    end
    @(negedge clk);
    kp.Col = 4'd0;
    #1 chk("col0", kp.Row, 0);
    kp.Col = 4'hf;
    #1 chk("col15", kp.Row, 4'b0100);
    wait_done("colsel_done");
    press(4'd6, 8'd10, 3'd0);
    @(negedge clk);
    chk("mid_hold_row", kp.Row, 4'b0010);
    reset = 1'b1;
    kp.cmd_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_row", kp.Row, 0);
    chk("mid_rst_busy", kp.busy, 0);
    chk("mid_rst_ready", kp.cmd_ready, 0);
    chk("mid_rst_done", kp.done, 0);
    @(negedge clk);
    chk("rst_valid_ignored", kp.busy, 0);
    kp.cmd_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", kp.done, 0);
    end
    chk("ready_after_rst", kp.cmd_ready, 1);
    press(4'd15, 8'd0, 3'd0);
    trace("post_rst_row", 32'b10000, 5, 4'b1000);
    end_chk("post_rst", 8'd1);
    @(negedge clk);
    kp.cmd_key = 4'd6;
    kp.cmd_hold = 8'd1;
    kp.cmd_bounce = 3'd0;
    kp.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    kp.cmd_key = 4'd9;
    kp.cmd_hold = 8'd2;
    trace("b2b_first_row", 32'b10000, 5, 4'b0010);
    @(negedge clk);
    chk("b2b_done", kp.done, 1);
    chk("b2b_ready", kp.cmd_ready, 1);
    chk("b2b_hit1", kp.hit_count, 1);
    @(posedge clk);
    #1 kp.cmd_valid = 1'b0;
    trace("b2b_second_row", 32'b110000, 6, 4'b0100);
    end_chk("b2b_second", 8'd2);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
